// File: rtl/modn_step_sched.sv
// modn_step_sched: owns a mod-N position register and round-robin arbitrates
// between two requesters, each commanding a run of K single up/down steps.
// The position advances one step per clock; completion is a one-cycle done.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for a request; grants one requester when any is high
//   RUN    | stepping pos once per clock until remaining reaches zero
//   DONE   | done pulse cycle; hands the round-robin pointer to owner

module modn_step_sched #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [1:0]   up,
  input  logic [W-1:0] steps0,
  input  logic [W-1:0] steps1,
  output logic [1:0]   gnt,
  output logic         owner,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] pos,
  output logic [W-1:0] remaining
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0] P_MAX = W'(N - 1);
  localparam logic [W-1:0] P_ONE = W'(1);

  logic [1:0]   r_state;
  logic [W-1:0] r_pos;
  logic [W-1:0] r_rem;
  logic [1:0]   r_gnt;
  logic         r_done;
  logic         r_busy;
  logic         r_owner;
  logic         r_last;
  logic         r_up;

  logic         w_pick;
  logic [W-1:0] w_steps;

  // Winner selection: on contention the requester that did not go last wins.
  always_comb begin
    w_pick  = (req == 2'b11) ? ~r_last : req[1];
    w_steps = w_pick ? steps1 : steps0;
  end

  // Sequencer: grant, step the position, then emit a single done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_rem   <= '0;
      r_gnt   <= 2'b00;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_up    <= 1'b0;
    end else begin
      r_gnt <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_owner <= w_pick;
            r_up    <= up[w_pick];
            r_rem   <= w_steps;
            r_busy  <= 1'b1;
            r_state <= (w_steps != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (r_up) r_pos <= (r_pos == P_MAX) ? '0 : r_pos + P_ONE;
          else      r_pos <= (r_pos == '0) ? P_MAX : r_pos - P_ONE;
          r_rem <= r_rem - P_ONE;
          if (r_rem == P_ONE) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          // A zero-step command arrives here with done still low; it spends
          // one extra cycle so that done never coincides with gnt.
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= r_owner;
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pos       = r_pos;
  assign remaining = r_rem;

endmodule

// File: tb/tb_modn_step_sched.sv
// Directed bench for modn_step_sched (N=10, W=4) with hand-computed vectors.

module tb_modn_step_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] up;
  logic [3:0] steps0;
  logic [3:0] steps1;
  logic [1:0] gnt;
  logic       owner;
  logic       busy;
  logic       done;
  logic [3:0] pos;
  logic [3:0] remaining;

  int n_chk = 0;
  int n_bad = 0;

  modn_step_sched #(.N(10), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .up        (up),
    .steps0    (steps0),
    .steps1    (steps1),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .done      (done),
    .pos       (pos),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full command from IDLE: grant, wait for done (bounded), check final pos
  task automatic do_cmd(input int i, input bit u, input int k, input int exp_pos);
    bit seen;
    req[i] = 1'b1;
    up[i]  = u;
    if (i == 0) steps0 = 4'(k); else steps1 = 4'(k);
    tick();
    chk("cmd_gnt", gnt, (i == 0) ? 1 : 2);
    req[i] = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("cmd_done_seen", seen, 1);
    chk("cmd_pos", pos, exp_pos);
    tick();
    chk("cmd_busy_low", busy, 0);
  endtask

  int up_seq [4] = '{9, 0, 1, 2};
  int dones;

  initial begin
    rst = 1'b1; req = 2'b00; up = 2'b00; steps0 = '0; steps1 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pos", pos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);

    // reset mid-run: K=7 up, two steps done, then reset
    req = 2'b01; up = 2'b01; steps0 = 4'd7;
    tick();
    chk("a_gnt", gnt, 1);
    chk("a_rem", remaining, 7);
    req = 2'b00;
    tick(); tick();
    chk("a_pos2", pos, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("a_rst_pos", pos, 0);
    chk("a_rst_busy", busy, 0);
    chk("a_rst_done", done, 0);
    chk("a_rst_gnt", gnt, 0);
    chk("a_rst_rem", remaining, 0);
    dones = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (done) dones++;
    end
    chk("a_no_done", dones, 0);

    // up wrap from 8, K=4
    do_cmd(0, 1'b1, 8, 8);
    req = 2'b01; up = 2'b01; steps0 = 4'd4;
    tick();
    chk("b_gnt", gnt, 1);
    chk("b_done_at_gnt", done, 0);
    req = 2'b00;
    dones = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("b_pos", pos, up_seq[j]);
      if (done) dones++;
    end
    chk("b_done_last", done, 1);
    chk("b_busy_at_done", busy, 1);
    tick();
    chk("b_busy_low", busy, 0);
    chk("b_done_low", done, 0);
    chk("b_one_done", dones, 1);

    // down wrap from 1 with K=13 on requester 1
    do_cmd(1, 1'b0, 1, 1);
    req = 2'b10; up = 2'b00; steps1 = 4'd13;
    tick();
    chk("c_gnt", gnt, 2);
    chk("c_owner", owner, 1);
    chk("c_rem0", remaining, 13);
    req = 2'b00;
    for (int j = 1; j <= 13; j++) begin
      tick();
      chk("c_rem", remaining, 13 - j);
    end
    chk("c_pos", pos, 8);
    chk("c_done", done, 1);
    tick();
    chk("c_busy_low", busy, 0);

    // zero-step command from pos 5
    do_cmd(0, 1'b0, 3, 5);
    req = 2'b01; steps0 = 4'd0;
    tick();
    chk("d_gnt", gnt, 1);
    chk("d_done0", done, 0);
    chk("d_busy0", busy, 1);
    req = 2'b00;
    tick();
    chk("d_gnt_low", gnt, 0);
    chk("d_done1", done, 1);
    chk("d_busy1", busy, 1);
    chk("d_pos", pos, 5);
    tick();
    chk("d_done2", done, 0);
    chk("d_busy2", busy, 0);

    // arbitration: both held, K=2 each, grants alternate every 4 edges
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b11; up = 2'b11; steps0 = 4'd2; steps1 = 4'd2;
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("e_gnt", gnt, (t % 4 == 1) ? (((t / 4) % 2 == 0) ? 1 : 2) : 0);
    end
    req = 2'b00;
    chk("e_pos", pos, 8);
    chk("e_busy", busy, 0);

    // late request from requester 1 and mid-run input changes on requester 0
    req = 2'b01; up = 2'b01; steps0 = 4'd3;
    tick();
    chk("f_gnt0", gnt, 1);
    req = 2'b00;
    tick();
    chk("f_pos9", pos, 9);
    req = 2'b10; up = 2'b00; steps0 = 4'd9; steps1 = 4'd1;
    tick();
    chk("f_pos0", pos, 0);
    chk("f_no_gnt_run", gnt, 0);
    tick();
    chk("f_pos1", pos, 1);
    chk("f_done", done, 1);
    chk("f_no_gnt_done", gnt, 0);
    tick();
    chk("f_idle_gnt", gnt, 0);
    chk("f_idle_busy", busy, 0);
    tick();
    chk("f_gnt1", gnt, 2);
    req = 2'b00;
    tick();
    chk("f_pos_down", pos, 0);
    chk("f_done1", done, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
